// File: rtl/t_count_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// t_count_ctrl_pkg
// Shared definitions for the T-cell count sequencer:
//   - default bank width and count modulus
//   - FSM state encoding
// ---------------------------------------------------------------------------
package t_count_ctrl_pkg;

  localparam int unsigned DEF_WIDTH = 4;
  localparam int unsigned DEF_MOD   = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/t_count_next.sv
// ---------------------------------------------------------------------------
// t_count_next
// Combinational mod-MOD successor/predecessor of the shadow count.
// Ports:
//   i_count  WIDTH  current shadow count (0..MOD-1)
//   i_up_dn  1      1 = increment, 0 = decrement
//   o_nxt    WIDTH  next count value
//   o_wrap   1      step crosses the modulus boundary (MOD-1->0 or 0->MOD-1)
// ---------------------------------------------------------------------------
module t_count_next
  import t_count_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned MOD   = DEF_MOD
) (
  input  logic [WIDTH-1:0] i_count,
  input  logic             i_up_dn,
  output logic [WIDTH-1:0] o_nxt,
  output logic             o_wrap
);

  localparam logic [WIDTH-1:0] C_MAX = WIDTH'(MOD - 1);
  localparam logic [WIDTH-1:0] C_ONE = WIDTH'(1);

  always_comb begin
    o_nxt  = i_count;
    o_wrap = 1'b0;
    if (i_up_dn) begin
      if (i_count == C_MAX) begin
        o_nxt  = '0;
        o_wrap = 1'b1;
      end else begin
        o_nxt = i_count + C_ONE;
      end
    end else begin
      if (i_count == '0) begin
        o_nxt  = C_MAX;
        o_wrap = 1'b1;
      end else begin
        o_nxt = i_count - C_ONE;
      end
    end
  end

endmodule

// File: rtl/t_count_ctrl.sv
// ---------------------------------------------------------------------------
// t_count_ctrl
// Sequencer for an external bank of WIDTH toggle cells. Keeps a shadow count,
// issues registered per-bit toggle requests so the bank counts mod-MOD up or
// down, and compares the bank read-back against the shadow count.
//
// Ports:
//   i_clk        rising-edge clock
//   i_rst        synchronous active-high reset
//   i_start      enter RUN from IDLE/HOLD
//   i_stop       RUN->HOLD, HOLD->IDLE
//   i_up_dn      count direction, sampled every RUN cycle
//   i_one_shot   stop after one wrap, latched on IDLE->RUN
//   i_load       IDLE only: load i_load_val (clamped to MOD-1)
//   i_load_val   load value
//   i_q_fb       bank read-back
//   o_t_vec      per-bit toggle request, valid with o_en
//   o_en         bank enable
//   o_count      shadow count
//   o_busy       RUN or HOLD
//   o_done       one-cycle one-shot completion pulse
//   o_err        sticky read-back mismatch flag
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | parked; accepts load and start
// ST_RUN  | one step per cycle unless stop
// ST_HOLD | frozen; start resumes, stop alone returns to IDLE
// ST_DONE | one-shot finished; done pulse, then IDLE
// ---------------------------------------------------------------------------
module t_count_ctrl
  import t_count_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned MOD   = DEF_MOD
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic             i_up_dn,
  input  logic             i_one_shot,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic [WIDTH-1:0] i_q_fb,
  output logic [WIDTH-1:0] o_t_vec,
  output logic             o_en,
  output logic [WIDTH-1:0] o_count,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err
);

  localparam logic [WIDTH-1:0] C_MAX = WIDTH'(MOD - 1);

  state_e           r_state;
  state_e           w_state_nxt;

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_t_vec;
  logic             r_en;
  logic             r_one_shot;
  logic             r_chk;
  logic [WIDTH-1:0] r_exp;
  logic             r_err;

  logic [WIDTH-1:0] w_count_nxt;
  logic [WIDTH-1:0] w_t_vec_nxt;
  logic             w_en_nxt;
  logic             w_one_shot_nxt;
  logic [WIDTH-1:0] w_step;
  logic             w_wrap;
  logic [WIDTH-1:0] w_load_clamped;

  t_count_next #(
    .WIDTH (WIDTH),
    .MOD   (MOD)
  ) u_next (
    .i_count (r_count),
    .i_up_dn (i_up_dn),
    .o_nxt   (w_step),
    .o_wrap  (w_wrap)
  );

  assign w_load_clamped = (i_load_val > C_MAX) ? C_MAX : i_load_val;

  // State register plus the registered bank-control outputs that the output
  // logic decides one cycle ahead.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_count    <= '0;
      r_t_vec    <= '0;
      r_en       <= 1'b0;
      r_one_shot <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_count    <= w_count_nxt;
      r_t_vec    <= w_t_vec_nxt;
      r_en       <= w_en_nxt;
      r_one_shot <= w_one_shot_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        // load wins over start in the same cycle
        if (!i_load && i_start) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (i_stop) begin
          w_state_nxt = ST_HOLD;
        end else if (w_wrap && r_one_shot) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_HOLD: begin
        if (i_start) begin
          w_state_nxt = ST_RUN;
        end else if (i_stop) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    w_count_nxt    = r_count;
    w_t_vec_nxt    = '0;
    w_en_nxt       = 1'b0;
    w_one_shot_nxt = r_one_shot;
    case (r_state)
      ST_IDLE: begin
        if (i_load) begin
          w_count_nxt = w_load_clamped;
          w_t_vec_nxt = r_count ^ w_load_clamped;
          w_en_nxt    = 1'b1;
        end else if (i_start) begin
          w_one_shot_nxt = i_one_shot;
        end
      end
      ST_RUN: begin
        if (!i_stop) begin
          w_count_nxt = w_step;
          w_t_vec_nxt = r_count ^ w_step;
          w_en_nxt    = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  // Read-back check. The bank applies t_vec at the edge that ends the en
  // cycle, so q_fb holds the result during the following cycle; the count
  // seen during the en cycle is held in r_exp for that comparison because
  // r_count may already have moved on by then.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_chk <= 1'b0;
      r_exp <= '0;
      r_err <= 1'b0;
    end else begin
      r_chk <= r_en;
      r_exp <= r_count;
      if (r_chk && (i_q_fb != r_exp)) begin
        r_err <= 1'b1;
      end
    end
  end

  always_comb begin
    o_busy = (r_state == ST_RUN) || (r_state == ST_HOLD);
    o_done = (r_state == ST_DONE);
  end

  assign o_t_vec = r_t_vec;
  assign o_en    = r_en;
  assign o_count = r_count;
  assign o_err   = r_err;

endmodule

// File: tb/tb_t_count_ctrl.sv
module tb_t_count_ctrl;

  localparam int W = 4;
  localparam int M = 10;

  localparam int MI = 0;
  localparam int MR = 1;
  localparam int MH = 2;
  localparam int MD = 3;

  logic         clk = 1'b0;
  logic         rst, start, stop, up_dn, one_shot, load;
  logic [W-1:0] load_val;
  logic [W-1:0] q_fb;
  logic [W-1:0] t_vec, count;
  logic         en, busy, done, err;

  logic [W-1:0] bank_q;
  logic [W-1:0] stuck_mask;
  logic         bank_clr;

  int n_checks = 0;
  int n_errs   = 0;

  always #5 clk = ~clk;

  t_count_ctrl #(.WIDTH(W), .MOD(M)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start    (start),
    .i_stop     (stop),
    .i_up_dn    (up_dn),
    .i_one_shot (one_shot),
    .i_load     (load),
    .i_load_val (load_val),
    .i_q_fb     (q_fb),
    .o_t_vec    (t_vec),
    .o_en       (en),
    .o_count    (count),
    .o_busy     (busy),
    .o_done     (done),
    .o_err      (err)
  );

  // Bank of T flip-flops; stuck_mask forces read-back bits to 0.
  always @(posedge clk) begin
    if (bank_clr) bank_q <= '0;
    else if (en)  bank_q <= bank_q ^ t_vec;
  end
  assign q_fb = bank_q & ~stuck_mask;

  // Behavioural reference: modular arithmetic on integers.
  int m_mode, m_count, m_tvec, m_chk_val;
  bit m_en, m_os, m_chk, m_err;

  always @(posedge clk) begin : model
    int v;
    int nx;
    bit wrap;
    if (rst) begin
      m_mode <= MI; m_count <= 0; m_tvec <= 0; m_en <= 0;
      m_os <= 0; m_chk <= 0; m_chk_val <= 0; m_err <= 0;
    end else begin
      if (m_chk && int'(q_fb) != m_chk_val) m_err <= 1;
      m_chk     <= m_en;
      m_chk_val <= m_count;
      m_en      <= 0;
      m_tvec    <= 0;
      case (m_mode)
        MI: begin
          if (load) begin
            v = (int'(load_val) >= M) ? M - 1 : int'(load_val);
            m_tvec  <= m_count ^ v;
            m_en    <= 1;
            m_count <= v;
          end else if (start) begin
            m_mode <= MR;
            m_os   <= one_shot;
          end
        end
        MR: begin
          if (stop) m_mode <= MH;
          else begin
            nx   = up_dn ? (m_count + 1) % M : (m_count + M - 1) % M;
            wrap = up_dn ? (nx < m_count) : (nx > m_count);
            m_tvec  <= m_count ^ nx;
            m_en    <= 1;
            m_count <= nx;
            if (wrap && m_os) m_mode <= MD;
          end
        end
        MH: begin
          if (start)     m_mode <= MR;
          else if (stop) m_mode <= MI;
        end
        default: m_mode <= MI;
      endcase
    end
  end

  function automatic logic [11:0] exp_out();
    return {4'(m_count), 4'(m_tvec), m_en, (m_mode == MR || m_mode == MH),
            (m_mode == MD), m_err};
  endfunction

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    start = 0; stop = 0; load = 0; one_shot = 0; up_dn = 1; load_val = '0;
  endtask

  task automatic test_reset();
    rst = 1; bank_clr = 1; idle_inputs(); stuck_mask = '0;
    cyc(); cyc();
    rst = 0; bank_clr = 0;
    n_checks++;
    if ({count, en, busy, done, err, t_vec} !== 12'h0) begin
      n_errs++;
      $display("FAIL reset got count=%0d en=%b busy=%b done=%b err=%b t_vec=%b want all 0",
               count, en, busy, done, err, t_vec);
    end
    cyc();
    n_checks++;
    if ({count, t_vec, en, busy, done, err} !== exp_out()) begin
      n_errs++; $display("FAIL reset_idle got %h want %h", {count, t_vec, en, busy, done, err}, exp_out());
    end
  endtask

  task automatic test_count_up();
    start = 1; up_dn = 1; one_shot = 0;
    cyc();
    start = 0;
    for (int i = 0; i < 12; i++) begin
      cyc();
      n_checks++;
      if (count !== 4'((i + 1) % M) || err !== 1'b0) begin
        n_errs++; $display("FAIL up_count step %0d got count=%0d err=%b want %0d err=0", i, count, err, (i + 1) % M);
      end
      if (i == 0 || i == 9) begin
        n_checks++;
        if (t_vec !== ((i == 0) ? 4'b0001 : 4'b1001) || en !== 1'b1) begin
          n_errs++; $display("FAIL up_tvec step %0d got t_vec=%b en=%b", i, t_vec, en);
        end
      end
      n_checks++;
      if ({count, t_vec, en, busy, done, err} !== exp_out()) begin
        n_errs++; $display("FAIL up_model step %0d got %h want %h", i, {count, t_vec, en, busy, done, err}, exp_out());
      end
    end
    stop = 1; cyc(); cyc(); stop = 0;
  endtask

  task automatic test_load();
    load = 1; load_val = 4'd0; cyc();
    load_val = 4'd13; cyc();
    n_checks++;
    if (t_vec !== 4'b1001 || count !== 4'd9 || en !== 1'b1) begin
      n_errs++; $display("FAIL load_clamp got t_vec=%b count=%0d en=%b want 1001 9 1", t_vec, count, en);
    end
    start = 1; load_val = 4'($urandom_range(0, 15)); cyc(); start = 0; load = 0;
    cyc();
    n_checks++;
    if (busy !== 1'b0) begin
      n_errs++; $display("FAIL load_beats_start got busy=%b want 0", busy);
    end
    for (int i = 0; i < 10; i++) begin
      load = 1; load_val = 4'($urandom_range(0, 15)); cyc();
      n_checks++;
      if ({count, t_vec, en, busy, done, err} !== exp_out()) begin
        n_errs++; $display("FAIL load_rand %0d got %h want %h", i, {count, t_vec, en, busy, done, err}, exp_out());
      end
    end
    load = 0; cyc();
  endtask

  task automatic test_down();
    load = 1; load_val = 4'd0; cyc(); load = 0;
    start = 1; up_dn = 0; cyc(); start = 0;
    cyc();
    n_checks++;
    if (count !== 4'd9 || t_vec !== 4'b1001) begin
      n_errs++; $display("FAIL down_wrap got count=%0d t_vec=%b want 9 1001", count, t_vec);
    end
    for (int i = 0; i < 20; i++) begin
      up_dn = 1'($urandom_range(0, 1)); cyc();
      n_checks++;
      if ({count, t_vec, en, busy, done, err} !== exp_out()) begin
        n_errs++; $display("FAIL dir_rand %0d got %h want %h", i, {count, t_vec, en, busy, done, err}, exp_out());
      end
    end
    up_dn = 1; stop = 1; cyc(); cyc(); stop = 0;
  endtask

  task automatic test_one_shot();
    int pulses = 0;
    load = 1; load_val = 4'd7; cyc(); load = 0;
    start = 1; one_shot = 1; up_dn = 1; cyc(); start = 0; one_shot = 0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      if (done === 1'b1) pulses++;
      n_checks++;
      if ({count, t_vec, en, busy, done, err} !== exp_out()) begin
        n_errs++; $display("FAIL oneshot %0d got %h want %h", i, {count, t_vec, en, busy, done, err}, exp_out());
      end
    end
    n_checks++;
    if (pulses != 1 || busy !== 1'b0 || count !== 4'd0) begin
      n_errs++; $display("FAIL oneshot_end got pulses=%0d busy=%b count=%0d want 1 0 0", pulses, busy, count);
    end
  endtask

  task automatic test_hold();
    load = 1; load_val = 4'd2; cyc(); load = 0;
    start = 1; cyc(); start = 0;
    cyc();
    stop = 1; cyc(); stop = 0;
    n_checks++;
    if (count !== 4'd3 || en !== 1'b0 || busy !== 1'b1) begin
      n_errs++; $display("FAIL hold_enter got count=%0d en=%b busy=%b want 3 0 1", count, en, busy);
    end
    cyc();
    n_checks++;
    if (count !== 4'd3 || en !== 1'b0 || busy !== 1'b1) begin
      n_errs++; $display("FAIL hold_stay got count=%0d en=%b busy=%b want 3 0 1", count, en, busy);
    end
    start = 1; cyc(); start = 0;
    cyc();
    n_checks++;
    if (count !== 4'd4) begin
      n_errs++; $display("FAIL hold_resume got count=%0d want 4", count);
    end
    stop = 1; cyc();
    start = 1; cyc(); start = 0; stop = 0;
    cyc();
    n_checks++;
    if (count !== 4'd5 || busy !== 1'b1 || {count, t_vec, en, busy, done, err} !== exp_out()) begin
      n_errs++; $display("FAIL hold_start_prio got count=%0d busy=%b want 5 1", count, busy);
    end
    stop = 1; cyc(); cyc(); stop = 0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      start    = ($urandom_range(0, 3) == 0);
      stop     = ($urandom_range(0, 7) == 0);
      load     = ($urandom_range(0, 3) == 0);
      up_dn    = 1'($urandom_range(0, 1));
      one_shot = 1'($urandom_range(0, 1));
      load_val = 4'($urandom_range(0, 15));
      cyc();
      n_checks++;
      if ({count, t_vec, en, busy, done, err} !== exp_out()) begin
        n_errs++; $display("FAIL random %0d got %h want %h", i, {count, t_vec, en, busy, done, err}, exp_out());
      end
    end
    idle_inputs(); stop = 1; cyc(); cyc(); cyc(); stop = 0;
  endtask

  task automatic test_rst_mid_run();
    load = 1; load_val = 4'd5; cyc(); load = 0;
    start = 1; cyc(); start = 0;
    cyc();
    n_checks++;
    if (count !== 4'd6 || busy !== 1'b1) begin
      n_errs++; $display("FAIL rst_pre got count=%0d busy=%b want 6 1", count, busy);
    end
    rst = 1; bank_clr = 1; cyc(); rst = 0; bank_clr = 0;
    n_checks++;
    if (count !== 4'd0 || en !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
      n_errs++; $display("FAIL rst_mid got count=%0d en=%b busy=%b err=%b want 0 0 0 0", count, en, busy, err);
    end
  endtask

  task automatic test_fault();
    stuck_mask = 4'b0001;
    load = 1; load_val = 4'd0; cyc(); load = 0;
    start = 1; up_dn = 1; cyc(); start = 0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (i == 0) begin
        n_checks++;
        if (err !== 1'b0) begin
          n_errs++; $display("FAIL fault_early got err=%b want 0", err);
        end
      end
      n_checks++;
      if ({count, t_vec, en, busy, done, err} !== exp_out()) begin
        n_errs++; $display("FAIL fault_model %0d got %h want %h", i, {count, t_vec, en, busy, done, err}, exp_out());
      end
    end
    stop = 1; cyc(); cyc(); stop = 0; stuck_mask = '0;
    cyc(); cyc(); cyc();
    n_checks++;
    if (err !== 1'b1) begin
      n_errs++; $display("FAIL fault_sticky got err=%b want 1", err);
    end
    rst = 1; bank_clr = 1; cyc(); rst = 0; bank_clr = 0;
    n_checks++;
    if (err !== 1'b0) begin
      n_errs++; $display("FAIL fault_clear got err=%b want 0", err);
    end
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_load();
    test_down();
    test_one_shot();
    test_hold();
    test_random();
    test_rst_mid_run();
    test_fault();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
